// File: rtl/uart_baudgen.sv
// Baud tick generator: one-cycle registered tick every DIV clocks, first tick DIV edges after reset.
// No backpressure and no enable; free-runs whenever out of reset, truncation error left uncompensated.
module uart_baudgen #(
  parameter int BAUD              = 9600,
  parameter int clk_freq          = 50_000_000,
  parameter int oversampling_rate = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV_RAW = clk_freq / (BAUD * oversampling_rate);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] count;
  logic          w_wrap;

  // Out-of-range codes wrap exactly like the terminal count, so a corrupted counter self-heals.
  generate
    if (DIV == 1) begin : g_div1
      assign w_wrap = 1'b1;
    end else begin : g_divn
      assign w_wrap = (count >= TERM);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (w_wrap) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + CW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baudgen.sv
// Directed bench for uart_baudgen: default (DIV=325), 115200 baud (DIV=27) and a forced DIV=1 instance.
module tb_uart_baudgen;

  logic clk;
  logic rst;
  logic tick_def, tick_fast, tick_one;

  int n_checks = 0;
  int n_errors = 0;

  uart_baudgen dut (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_def)
  );

  uart_baudgen #(.BAUD(115200), .clk_freq(50_000_000), .oversampling_rate(16)) dut_fast (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_fast)
  );

  uart_baudgen #(.BAUD(9600), .clk_freq(100), .oversampling_rate(16)) dut_one (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_one)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected state after edge k (k >= 1) following reset release, for a given divider.
  function automatic int exp_count(input int k, input int div);
    return k % div;
  endfunction

  function automatic int exp_tick(input int k, input int div);
    return (k >= div && (k % div) == 0) ? 1 : 0;
  endfunction

  // Advance n edges after release, comparing all three instances against the model each edge.
  task automatic run_edges(input int start_k, input int n, input string tag);
    for (int k = start_k; k < start_k + n; k++) begin
      @(posedge clk);
      #1;
      chk({tag, " def.count"},  int'(dut.count),      exp_count(k, 325));
      chk({tag, " def.tick"},   int'(tick_def),       exp_tick(k, 325));
      chk({tag, " fast.count"}, int'(dut_fast.count), exp_count(k, 27));
      chk({tag, " fast.tick"},  int'(tick_fast),      exp_tick(k, 27));
      chk({tag, " one.count"},  int'(dut_one.count),  0);
      chk({tag, " one.tick"},   int'(tick_one),       exp_tick(k, 1));
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " def.count"},  int'(dut.count),      0);
    chk({tag, " def.tick"},   int'(tick_def),       0);
    chk({tag, " fast.count"}, int'(dut_fast.count), 0);
    chk({tag, " fast.tick"},  int'(tick_fast),      0);
    chk({tag, " one.tick"},   int'(tick_one),       0);
  endtask

  // Pulse reset across one rising edge and release just after it.
  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_cleared("in_reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("por");
    chk("cw.def",  $bits(dut.count),      9);
    chk("cw.fast", $bits(dut_fast.count), 5);
    chk("cw.one",  $bits(dut_one.count),  1);
    rst = 1'b0;

    // Five full default periods plus one edge: ticks only at multiples of 325.
    run_edges(1, 5 * 325 + 1, "freerun");

    // Ten back-to-back reset/release cycles must each restart the full latency.
    for (int it = 0; it < 10; it++) begin
      reset_pulse();
      run_edges(1, 326, "rerun");
    end

    // Asynchronous reset mid-period, between clock edges.
    reset_pulse();
    run_edges(1, 150, "pre_mid");
    chk("mid.count_nonzero", int'(dut.count != '0), 1);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async_mid");
    rst = 1'b0;
    run_edges(1, 326, "post_mid");

    // Asynchronous reset during the cycle tick is high.
    reset_pulse();
    run_edges(1, 325, "pre_tick");
    chk("tickhigh.before", int'(tick_def), 1);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async_tick");
    rst = 1'b0;
    run_edges(1, 326, "post_tick");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL timeout: bench did not complete");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
